sbox_layer_sched: RTL and testbench
===================================

SBOX_LAYER_SCHED -- requirements
Module: sbox_layer_sched

Interface
REQ-001 SHALL have parameter LAT, default 4: cycles from driving an input byte on sb_in* to its result on sb_out*.
REQ-002 SHALL have parameter NBYTES, default 8: bytes per 64-bit share of the state (two nibbles per byte).
REQ-003 SHALL have ports clk (input, 1): single clock; all logic on the rising edge.
REQ-004 SHALL have port rst (input, 1): synchronous, active-high reset.
REQ-005 SHALL have ports start (in, 1), busy (out, 1), done (out, 1): layer command and status.
REQ-006 SHALL have ports st1_in, st2_in, st3_in (in, 64 each): masked state shares, sampled on an accepted start.
REQ-007 SHALL have ports st1_out, st2_out, st3_out (out, 64 each): S-box layer result shares.
REQ-008 SHALL have ports rnd_data (in, 192), rnd_valid (in, 1), rnd_ready (out, 1): fresh-mask source handshake.
REQ-009 SHALL have ports sb_in1, sb_in2, sb_in3 (out, 8 each) and sb_r (out, 192): drive to the external two-S-box masked datapath.
REQ-010 SHALL have ports sb_out1, sb_out2, sb_out3 (in, 8 each): result from the datapath.

Function
REQ-011 SHALL use FSM states IDLE, ISSUE, DRAIN, DONE.
- IDLE->ISSUE on start.
- ISSUE->DRAIN after issue of byte NBYTES-1.
- DRAIN->DONE when no tag is in flight and all NBYTES results are captured.
- DONE->IDLE unconditionally.
REQ-012 SHALL accept start only in IDLE; start in any other state is ignored.
REQ-013 SHALL copy st*_in into internal share registers on the cycle start is accepted.
REQ-014 SHALL assert rnd_ready exactly while in ISSUE, regardless of rnd_valid.
REQ-015 SHALL issue a byte only in a cycle with rnd_valid && rnd_ready.
- On issue: sb_inK = share K byte[idx] (bits 8*idx+7:8*idx), sb_r = rnd_data, then idx increments.
- Byte order is 0 to NBYTES-1.
REQ-016 SHALL drive sb_in* and sb_r to all-zero in every non-issue cycle, including stall bubbles. Stale shares and masks are never re-presented to the datapath.
REQ-017 SHALL treat the datapath as free-running, with no enable. Each issue pushes a valid bit and byte index into a LAT-deep tag pipe; bubbles push valid=0.
REQ-018 SHALL capture sb_outK into byte[tag idx] of stK_out when the tag pipe's output stage holds valid=1. Nothing is written otherwise.
REQ-019 SHALL hold busy=1 in ISSUE and DRAIN, and busy=0 in IDLE and DONE.
REQ-020 SHALL pulse done high for exactly one cycle, in state DONE.
REQ-021 SHALL hold st*_out stable from DONE until the next capture of a subsequent run.
REQ-022 SHALL take exactly NBYTES+LAT+1 cycles from the start edge to done with rnd_valid held high (13 for default parameters). Each stall cycle adds exactly one cycle.
REQ-023 SHALL use the byte counter width clog2(NBYTES). The counter does not wrap past NBYTES-1 within a run.
REQ-024 SHALL give a stall in the final ISSUE cycle no special handling: the FSM stays in ISSUE until byte NBYTES-1 is issued.

Reset
REQ-025 SHALL on rst, from any state including mid-run, set:
- state=IDLE;
- idx=0;
- all tag valid bits=0;
- busy=0, done=0, rnd_ready=0;
- sb_in*, sb_r, st*_out and internal share registers all zero.
REQ-026 SHALL give rst priority over start when both are asserted in the same cycle.
REQ-027 SHALL produce no capture or done from a run that was interrupted by reset.

Structure
REQ-028 SHALL place the FSM state enum, the default LAT/NBYTES values and the 192-bit randomness width constant in the shared package midori_sched_pkg.
REQ-029 SHALL implement the valid and index delay line as one sub-module, sched_tag_pipe (parameters LAT and index width, synchronous reset).
REQ-030 SHALL NOT instantiate the masked S-box datapath; the instantiation belongs to the parent.

Verification
REQ-031 No-stall run, using a LAT=4 reference pipe model:
- Stimulus: st1_in=0x0123456789ABCDEF, st2_in=st3_in=0, rnd_valid=1.
- Response: done 13 cycles after start; st1^st2^st3 equals the unmasked Midori S-box layer of 0x0123456789ABCDEF.
REQ-032 Stall run:
- Stimulus: rnd_valid low in the cycles of bytes 2 and 5 (3 stall cycles total).
- Response: done at 16 cycles; result identical to REQ-031; sb_in*=0 and sb_r=0 in each bubble.
REQ-033 Start while busy:
- Stimulus: a second start 3 cycles after the first.
- Response: ignored; exactly one done; st*_in changes after acceptance have no effect.
REQ-034 Reset mid-run:
- Stimulus: rst at cycle 6.
- Response: the next cycle shows busy=0, rnd_ready=0, st*_out=0; no done follows; a fresh start then completes in 13 cycles.
REQ-035 Back-to-back runs:
- Stimulus: start asserted in the cycle after done.
- Response: accepted; second result correct; first result held until overwritten byte by byte.

Source files
------------

// File: rtl/midori_sched_pkg.sv
// Purpose : shared constants and FSM encoding for the masked Midori S-box layer scheduler.
// Latency : n/a (declarations only).
// Backpr. : n/a.
// Contents: default datapath latency / byte count, fresh-mask width, scheduler state enum.
package midori_sched_pkg;

   localparam int LAT_DEF    = 4;    // external masked S-box pipeline depth
   localparam int NBYTES_DEF = 8;    // bytes per 64-bit share (two nibbles each)
   localparam int RND_W      = 192;  // fresh randomness consumed per issued byte

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/sched_tag_pipe.sv
// Purpose : delay line carrying a valid bit and byte index alongside the free-running datapath.
// Latency : LAT cycles from push to tail; one entry enters every cycle (bubbles enter as valid=0).
// Backpr. : none; the pipe never stalls, matching the datapath it shadows.
// Ports   : clk, rst (sync, active high); push_valid/push_idx enter stage 0;
//           tail_valid/tail_idx leave the last stage; pending = any stage holds a valid tag.
module sched_tag_pipe #(
   parameter int LAT = 4,
   parameter int IW  = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push_valid,
   input  logic [IW-1:0] push_idx,
   output logic          tail_valid,
   output logic [IW-1:0] tail_idx,
   output logic          pending
);

   logic [LAT-1:0] vld;
   logic [IW-1:0]  ix [LAT];

   always_ff @(posedge clk) begin
      if (rst) begin
         vld <= '0;
         for (int i = 0; i < LAT; i++) ix[i] <= '0;
      end else begin
         vld[0] <= push_valid;
         ix[0]  <= push_valid ? push_idx : '0;
         for (int i = 1; i < LAT; i++) begin
            vld[i] <= vld[i-1];
            ix[i]  <= ix[i-1];
         end
      end
   end

   assign tail_valid = vld[LAT-1];
   assign tail_idx   = ix[LAT-1];
   assign pending    = |vld;

endmodule

// File: rtl/sbox_layer_sched.sv
// Purpose : feeds a masked three-share state byte by byte through an external S-box datapath.
// Latency : NBYTES+LAT+1 cycles start->done, plus one cycle per rnd_valid stall.
// Backpr. : issue waits on rnd_valid; start is only accepted while idle.
// Ports   : clk, rst (sync, active high); start/busy/done command and status;
//           st1..3_in sampled on accepted start, st1..3_out hold the layer result;
//           rnd_data/rnd_valid/rnd_ready fresh-mask handshake;
//           sb_in1..3/sb_r drive the datapath, sb_out1..3 return LAT cycles later.
module sbox_layer_sched
   import midori_sched_pkg::*;
#(
   parameter int LAT    = LAT_DEF,
   parameter int NBYTES = NBYTES_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   input  logic [8*NBYTES-1:0]   st1_in,
   input  logic [8*NBYTES-1:0]   st2_in,
   input  logic [8*NBYTES-1:0]   st3_in,
   output logic [8*NBYTES-1:0]   st1_out,
   output logic [8*NBYTES-1:0]   st2_out,
   output logic [8*NBYTES-1:0]   st3_out,
   input  logic [RND_W-1:0]      rnd_data,
   input  logic                  rnd_valid,
   output logic                  rnd_ready,
   output logic [7:0]            sb_in1,
   output logic [7:0]            sb_in2,
   output logic [7:0]            sb_in3,
   output logic [RND_W-1:0]      sb_r,
   input  logic [7:0]            sb_out1,
   input  logic [7:0]            sb_out2,
   input  logic [7:0]            sb_out3
);

   localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam int CW = $clog2(NBYTES + 1);

   state_e                 state;
   logic [IW-1:0]          idx;
   logic [CW-1:0]          cap_cnt;
   logic [NBYTES-1:0][7:0] sh1, sh2, sh3;
   logic [NBYTES-1:0][7:0] res1, res2, res3;
   logic                   issue;
   logic                   tail_valid;
   logic [IW-1:0]          tail_idx;
   logic                   pending;

   assign rnd_ready = (state == ISSUE);
   assign issue     = rnd_ready && rnd_valid;
   assign busy      = (state == ISSUE) || (state == DRAIN);
   assign done      = (state == DONE);

   // Outside an issue cycle the datapath sees zeros, so a stalled or finished
   // scheduler never re-presents shares or masks it has already used.
   assign sb_in1 = issue ? sh1[idx] : 8'h00;
   assign sb_in2 = issue ? sh2[idx] : 8'h00;
   assign sb_in3 = issue ? sh3[idx] : 8'h00;
   assign sb_r   = issue ? rnd_data : '0;

   assign st1_out = res1;
   assign st2_out = res2;
   assign st3_out = res3;

   sched_tag_pipe #(
      .LAT (LAT),
      .IW  (IW)
   ) u_tag_pipe (
      .clk        (clk),
      .rst        (rst),
      .push_valid (issue),
      .push_idx   (idx),
      .tail_valid (tail_valid),
      .tail_idx   (tail_idx),
      .pending    (pending)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         idx   <= '0;
         sh1   <= '0;
         sh2   <= '0;
         sh3   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state <= ISSUE;
                  idx   <= '0;
                  sh1   <= st1_in;
                  sh2   <= st2_in;
                  sh3   <= st3_in;
               end
            end
            ISSUE: begin
               // idx parks on the last byte rather than wrapping.
               if (issue) begin
                  if (idx == IW'(NBYTES - 1)) state <= DRAIN;
                  else                        idx   <= idx + 1'b1;
               end
            end
            DRAIN: begin
               if (!pending && (cap_cnt == CW'(NBYTES))) state <= DONE;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Results land only when a live tag reaches the end of the pipe; bubbles
   // and anything in flight at reset never touch the output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cap_cnt <= '0;
         res1    <= '0;
         res2    <= '0;
         res3    <= '0;
      end else begin
         if ((state == IDLE) && start) cap_cnt <= '0;
         else if (tail_valid)          cap_cnt <= cap_cnt + 1'b1;
         if (tail_valid) begin
            res1[tail_idx] <= sb_out1;
            res2[tail_idx] <= sb_out2;
            res3[tail_idx] <= sb_out3;
         end
      end
   end

endmodule

// File: tb/tb_sbox_layer_sched.sv
module tb_sbox_layer_sched;
   import midori_sched_pkg::*;

   localparam int LAT = 4;
   localparam int NB  = 8;

   logic             clk = 1'b0;
   logic             rst, start, busy, done;
   logic [63:0]      st1_in, st2_in, st3_in, st1_out, st2_out, st3_out;
   logic [RND_W-1:0] rnd_data, sb_r;
   logic             rnd_valid, rnd_ready;
   logic [7:0]       sb_in1, sb_in2, sb_in3, sb_out1, sb_out2, sb_out3;

   always #5 clk = ~clk;

   sbox_layer_sched #(.LAT(LAT), .NBYTES(NB)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .st1_in(st1_in), .st2_in(st2_in), .st3_in(st3_in),
      .st1_out(st1_out), .st2_out(st2_out), .st3_out(st3_out),
      .rnd_data(rnd_data), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
      .sb_in1(sb_in1), .sb_in2(sb_in2), .sb_in3(sb_in3), .sb_r(sb_r),
      .sb_out1(sb_out1), .sb_out2(sb_out2), .sb_out3(sb_out3)
   );

   // Midori Sb0
   function automatic logic [3:0] sb4(input logic [3:0] x);
      case (x)
         4'h0: return 4'hC;  4'h1: return 4'hA;  4'h2: return 4'hD;  4'h3: return 4'h3;
         4'h4: return 4'hE;  4'h5: return 4'hB;  4'h6: return 4'hF;  4'h7: return 4'h7;
         4'h8: return 4'h8;  4'h9: return 4'h9;  4'hA: return 4'h1;  4'hB: return 4'h5;
         4'hC: return 4'h0;  4'hD: return 4'h2;  4'hE: return 4'h4;  default: return 4'h6;
      endcase
   endfunction

   function automatic logic [63:0] layer(input logic [63:0] x);
      logic [63:0] y;
      for (int i = 0; i < 16; i++) y[4*i +: 4] = sb4(x[4*i +: 4]);
      return y;
   endfunction

   // Stand-in masked datapath: unmasked S-box of the byte, re-shared with two mask bytes.
   function automatic logic [23:0] dp_f(input logic [7:0] x, input logic [7:0] m1, input logic [7:0] m2);
      logic [7:0] y;
      y = {sb4(x[7:4]), sb4(x[3:0])};
      return {m2, m1, y ^ m1 ^ m2};
   endfunction

   function automatic logic [63:0] r64();
      return {$urandom, $urandom};
   endfunction

   function automatic logic [191:0] r192();
      return {r64(), r64(), r64()};
   endfunction

   logic [23:0] dp [LAT];
   always @(posedge clk) begin
      dp[0] <= dp_f(sb_in1 ^ sb_in2 ^ sb_in3, sb_r[7:0], sb_r[191:184]);
      for (int i = 1; i < LAT; i++) dp[i] <= dp[i-1];
   end
   assign sb_out1 = dp[LAT-1][7:0];
   assign sb_out2 = dp[LAT-1][15:8];
   assign sb_out3 = dp[LAT-1][23:16];

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check_eq(input string tag, input logic [191:0] got, input logic [191:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   logic [191:0] rw [NB];
   int           stl [NB];
   logic [63:0]  prev1, prev2, prev3;

   task automatic set_run(input bit rnd_stalls);
      for (int i = 0; i < NB; i++) begin
         rw[i]  = r192();
         stl[i] = (rnd_stalls && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
      end
   endtask

   // One start..done run; sec_t >= 0 drives an extra start at that cycle,
   // rst_t >= 0 resets at that cycle and then watches for a stray done.
   task automatic do_run(input string nm, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] c, input int sec_t, input int rst_t);
      logic [63:0] e1, e2, e3;
      logic [23:0] r;
      int          issue_t [NB];
      int          k, t, stall_left, exp_t, ndone, done_t, e_rdy, e_sb, e_busy, e_hold;
      logic        v, aborted, nw;
      for (int i = 0; i < NB; i++) begin
         r = dp_f(a[8*i +: 8] ^ b[8*i +: 8] ^ c[8*i +: 8], rw[i][7:0], rw[i][191:184]);
         e1[8*i +: 8] = r[7:0];
         e2[8*i +: 8] = r[15:8];
         e3[8*i +: 8] = r[23:16];
         issue_t[i]   = 1 << 20;
      end
      exp_t = NB + LAT + 1;
      for (int i = 0; i < NB; i++) exp_t += stl[i];
      k = 0; t = 0; ndone = 0; done_t = -1;
      e_rdy = 0; e_sb = 0; e_busy = 0; e_hold = 0; aborted = 1'b0;

      @(posedge clk); #1;
      start = 1'b1; st1_in = a; st2_in = b; st3_in = c;
      rnd_valid = 1'b1; rnd_data = r192();
      @(negedge clk);
      check_eq({nm, ":idle_status"}, {busy, done, rnd_ready}, '0);
      check_eq({nm, ":idle_sb_r"}, sb_r, '0);
      check_eq({nm, ":idle_sb_in"}, {sb_in1, sb_in2, sb_in3}, '0);
      @(posedge clk); #1;
      start = 1'b0; st1_in = r64(); st2_in = r64(); st3_in = r64();
      stall_left = stl[0];

      forever begin
         start = (t == sec_t);
         if (t == sec_t) begin st1_in = r64(); st2_in = r64(); st3_in = r64(); end
         rst = (t == rst_t);
         if (k < NB && stall_left == 0) begin
            v = 1'b1; rnd_data = rw[k];
         end else begin
            v = (k < NB) ? 1'b0 : 1'($urandom_range(0, 1));
            rnd_data = r192();
         end
         rnd_valid = v;
         @(negedge clk);
         if (rst_t >= 0 && t == rst_t + 1) begin aborted = 1'b1; break; end
         if (rnd_ready !== (k < NB)) e_rdy++;
         if (busy !== (t < exp_t)) e_busy++;
         if (done === 1'b1) begin ndone++; done_t = t; end
         if (k < NB && v) begin
            if ({sb_in1, sb_in2, sb_in3} !== {a[8*k +: 8], b[8*k +: 8], c[8*k +: 8]} || sb_r !== rw[k]) e_sb++;
            issue_t[k] = t;
            k++;
            stall_left = (k < NB) ? stl[k] : 0;
         end else begin
            if ({sb_in1, sb_in2, sb_in3} !== 24'h0 || sb_r !== '0) e_sb++;
            if (k < NB) stall_left--;
         end
         for (int j = 0; j < NB; j++) begin
            nw = (issue_t[j] + LAT + 1 <= t);
            if (st1_out[8*j +: 8] !== (nw ? e1[8*j +: 8] : prev1[8*j +: 8])) e_hold++;
            if (st2_out[8*j +: 8] !== (nw ? e2[8*j +: 8] : prev2[8*j +: 8])) e_hold++;
            if (st3_out[8*j +: 8] !== (nw ? e3[8*j +: 8] : prev3[8*j +: 8])) e_hold++;
         end
         if (t >= exp_t || t > 100) break;
         @(posedge clk); #1;
         t++;
      end

      check_eq({nm, ":ready_errs"}, e_rdy, 0);
      check_eq({nm, ":issue_bubble_errs"}, e_sb, 0);
      check_eq({nm, ":hold_errs"}, e_hold, 0);
      if (aborted) begin
         check_eq({nm, ":rst_status"}, {busy, done, rnd_ready}, '0);
         check_eq({nm, ":rst_outs"}, {st1_out, st2_out, st3_out}, '0);
         check_eq({nm, ":rst_sb"}, {sb_in1, sb_in2, sb_in3}, '0);
         ndone = 0;
         repeat (20) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
         end
         check_eq({nm, ":no_done_after_rst"}, ndone, 0);
         prev1 = '0; prev2 = '0; prev3 = '0;
      end else begin
         check_eq({nm, ":busy_errs"}, e_busy, 0);
         check_eq({nm, ":done_cycle"}, 32'(done_t), 32'(exp_t));
         check_eq({nm, ":done_count"}, ndone, 1);
         check_eq({nm, ":share1"}, st1_out, e1);
         check_eq({nm, ":share2"}, st2_out, e2);
         check_eq({nm, ":share3"}, st3_out, e3);
         check_eq({nm, ":unmasked"}, st1_out ^ st2_out ^ st3_out, layer(a ^ b ^ c));
         prev1 = e1; prev2 = e2; prev3 = e3;
      end
   endtask

   logic [63:0] ra, rb, rc;

   initial begin
      rst = 1'b1; start = 1'b0; rnd_valid = 1'b0; rnd_data = '0;
      st1_in = '0; st2_in = '0; st3_in = '0;
      prev1 = '0; prev2 = '0; prev3 = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("reset_status", {busy, done, rnd_ready}, '0);
      check_eq("reset_outs", {st1_out, st2_out, st3_out}, '0);
      check_eq("reset_sb", sb_r | {168'h0, sb_in1, sb_in2, sb_in3}, '0);
      @(posedge clk); #1;
      rst = 1'b0;

      set_run(1'b0);
      do_run("nostall", 64'h0123456789ABCDEF, 64'h0, 64'h0, -1, -1);
      check_eq("nostall_layer_const", st1_out ^ st2_out ^ st3_out, 64'hCAD3EBF789150246);

      set_run(1'b0);
      stl[2] = 2; stl[5] = 1;
      do_run("stall", 64'h0123456789ABCDEF, 64'h0, 64'h0, -1, -1);
      check_eq("stall_layer_const", st1_out ^ st2_out ^ st3_out, 64'hCAD3EBF789150246);

      set_run(1'b0);
      do_run("b2b", r64(), r64(), r64(), -1, -1);

      set_run(1'b0);
      do_run("start_busy", r64(), r64(), r64(), 3, -1);

      set_run(1'b0);
      do_run("rst_mid", r64(), r64(), r64(), -1, 6);

      set_run(1'b0);
      do_run("after_rst", r64(), r64(), r64(), -1, -1);

      for (int n = 0; n < 6; n++) begin
         set_run(1'b1);
         ra = r64(); rb = r64(); rc = r64();
         do_run($sformatf("rand%0d", n), ra, rb, rc, -1, -1);
      end

      @(posedge clk); #1;
      rst = 1'b1; start = 1'b1; st1_in = r64();
      @(posedge clk); #1;
      rst = 1'b0; start = 1'b0;
      @(negedge clk);
      check_eq("rst_over_start_status", {busy, rnd_ready}, '0);
      check_eq("rst_over_start_outs", {st1_out, st2_out, st3_out}, '0);
      @(negedge clk);
      check_eq("rst_over_start_stays_idle", busy, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
